// File: rtl/seg_scroll_scanner.sv
// Multiplexed active-low 7-segment driver for the answering-machine front panel.
// Scans DIGITS positions and animates a loaded glyph buffer (static/reveal/blink/marquee).
module seg_scroll_scanner #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int STEP_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   text_in,
  input  logic [1:0]            mode_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     seg_en,
  output logic                  done
);

  localparam logic [1:0] MODE_STATIC  = 2'd0;
  localparam logic [1:0] MODE_REVEAL  = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_MARQUEE = 2'd3;

  localparam int IW = $clog2(DIGITS);
  localparam int SW = $clog2(DIGITS + 1);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(STEP_DIV);

  localparam logic [CW-1:0]     SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [TW-1:0]     STEP_LAST = TW'(STEP_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [SW-1:0]     S_FULL    = SW'(DIGITS);
  localparam logic [SW-1:0]     S_WRAP    = SW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_ONE    = DIGITS'(1);

  logic [4*DIGITS-1:0] text_q, text_d;
  logic [1:0]          mode_q, mode_d;
  logic [CW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       step_cnt_q, step_cnt_d;
  logic [SW-1:0]       s_q, s_d;
  logic                phase_q, phase_d;
  logic [7:0]          seg_out_q, seg_out_d;
  logic [DIGITS-1:0]   seg_en_q, seg_en_d;
  logic                done_q, done_d;

  logic                scan_wrap;
  logic                step_tick;
  logic                visible;
  logic [3:0]          glyph;

  function automatic logic [7:0] font(input logic [3:0] code);
    logic [7:0] f;
    case (code)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = 8'h8C;
      4'hB: f = 8'hC7;
      4'hC: f = 8'h92;
      4'hD: f = 8'hC6;
      4'hE: f = 8'hF1;
      default: f = 8'hFF;
    endcase
    return f;
  endfunction

  // Timing and animation state; load restarts the animation but never the scan.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    step_tick  = (step_cnt_q == STEP_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    text_d     = text_q;
    mode_d     = mode_q;
    step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    s_d        = s_q;
    phase_d    = phase_q;
    done_d     = done_q | ((mode_q == MODE_REVEAL) && (s_q == S_FULL));

    if (load) begin
      text_d     = text_in;
      mode_d     = mode_in;
      step_cnt_d = '0;
      s_d        = '0;
      phase_d    = 1'b0;
      done_d     = (mode_in == MODE_STATIC);
    end else if (step_tick) begin
      phase_d = ~phase_q;
      if (mode_q == MODE_REVEAL && s_q != S_FULL) begin
        s_d = s_q + 1'b1;
      end else if (mode_q == MODE_MARQUEE) begin
        s_d = (s_q == S_WRAP) ? '0 : s_q + 1'b1;
      end
    end
  end

  // Glyph for the currently scanned position; text[0] is the leftmost character.
  always_comb begin
    int p;
    int s_int;
    int pos;
    p       = int'(idx_q);
    s_int   = int'(s_q);
    pos     = DIGITS - 1 - p;
    visible = 1'b1;
    case (mode_q)
      MODE_REVEAL: begin
        if (s_int > p) pos = s_int - 1 - p;
        else           visible = 1'b0;
      end
      MODE_BLINK:   visible = ~phase_q;
      MODE_MARQUEE: begin
        pos = s_int + DIGITS - 1 - p;
        if (pos >= DIGITS) pos = pos - DIGITS;
      end
      default: ;
    endcase

    glyph = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == pos) glyph = text_q[4*i +: 4];
    end

    seg_out_d = visible ? font(glyph) : 8'hFF;
    seg_en_d  = visible ? ~(EN_ONE << idx_q) : '1;
  end

  // The glyph buffer is a handful of flops, so it resets with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_q     <= '1;
      mode_q     <= MODE_STATIC;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      step_cnt_q <= '0;
      s_q        <= '0;
      phase_q    <= 1'b0;
      seg_out_q  <= 8'hFF;
      seg_en_q   <= '1;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      text_q     <= text_d;
      mode_q     <= mode_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      step_cnt_q <= step_cnt_d;
      s_q        <= s_d;
      phase_q    <= phase_d;
      seg_out_q  <= seg_out_d;
      seg_en_q   <= seg_en_d;
      done_q     <= done_d;
    end
  end

  assign seg_out = seg_out_q;
  assign seg_en  = seg_en_q;
  assign done    = done_q;

endmodule
